// File: rtl/led_pwm_if.sv
// Colour/enable control and RGB drive/busy status bundle for led_pwm_driver.
// The master side owns colour and enable. The slave side (the driver) returns
// the PWM pin drive and the crossfade status.
interface led_pwm_if;
   logic [2:0] colour;
   logic       enable;
   logic [2:0] rgb;
   logic       busy;

   modport master (
      output colour,
      output enable,
      input  rgb,
      input  busy
   );

   modport slave (
      input  colour,
      input  enable,
      output rgb,
      output busy
   );
endinterface

// File: rtl/led_pwm_driver.sv
// Per-channel RGB PWM driver with a smooth crossfade.
// Each channel's duty steps toward full-on or full-off, depending on its colour
// bit. Steps happen only on PWM period boundaries, so a running period is never
// cut short or stretched.
module led_pwm_driver #(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 4,
   parameter int STEP     = 16
) (
   input logic      clk,
   input logic      rst,
   led_pwm_if.slave pwm
);

   localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
   localparam int                  PCNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(STEP_DIV - 1);
   localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(STEP);

   logic [PWM_BITS-1:0]      cnt;
   logic [PCNT_W-1:0]        pcnt;
   logic                     update;
   logic [2:0][PWM_BITS-1:0] duty;
   logic [2:0][PWM_BITS-1:0] duty_next;
   logic [2:0][PWM_BITS-1:0] target;
   logic [2:0][PWM_BITS:0]   gap;
   logic [2:0]               rgb_q;
   logic [2:0]               rgb_next;
   logic [2:0]               off_target;

   // Free-running PWM counter plus a period counter that paces the fade steps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         pcnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         if (cnt == MAX) begin
            if (pcnt == PCNT_LAST) begin
               pcnt <= '0;
            end else begin
               pcnt <= pcnt + 1'b1;
            end
         end
      end
   end

   assign update = (cnt == MAX) && (pcnt == PCNT_LAST);

   // Next duty for each channel: one step toward the target.
   // The gap is computed one bit wider so the landing test can never wrap.
   always_comb begin
      target    = '0;
      gap       = '0;
      duty_next = duty;
      for (int i = 0; i < 3; i++) begin
         target[i] = pwm.colour[i] ? MAX : '0;
         if (target[i] > duty[i]) begin
            gap[i] = {1'b0, target[i]} - {1'b0, duty[i]};
            if (gap[i] <= STEP_X) begin
               duty_next[i] = target[i];
            end else begin
               duty_next[i] = duty[i] + STEP_X[PWM_BITS-1:0];
            end
         end else if (target[i] < duty[i]) begin
            gap[i] = {1'b0, duty[i]} - {1'b0, target[i]};
            if (gap[i] <= STEP_X) begin
               duty_next[i] = target[i];
            end else begin
               duty_next[i] = duty[i] - STEP_X[PWM_BITS-1:0];
            end
         end
      end
   end

   // PWM compare. Full-scale duty is held high for the whole period.
   // Enable only masks the pins; it never touches the fade state.
   always_comb begin
      rgb_next = '0;
      for (int i = 0; i < 3; i++) begin
         rgb_next[i] = pwm.enable & ((duty[i] == MAX) | (cnt < duty[i]));
      end
   end

   // Duty registers change only at the end of a step period.
   // Pin drive is registered every cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         duty  <= '0;
         rgb_q <= '0;
      end else begin
         rgb_q <= rgb_next;
         if (update) begin
            duty <= duty_next;
         end
      end
   end

   // A channel is still fading while its duty differs from the live target
   always_comb begin
      off_target = '0;
      for (int i = 0; i < 3; i++) begin
         off_target[i] = (duty[i] != target[i]);
      end
   end

   assign pwm.rgb  = rgb_q;
   assign pwm.busy = rst & (|off_target);

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver. Three configurations run side by side:
//  - dut_a: defaults, compared every cycle against an edge-count model
//  - dut_b: STEP=100 fade table
//  - dut_c: 2-bit PWM with single-period steps
module tb_led_pwm_driver;

   localparam int P_A    = 256;
   localparam int MAX_A  = 255;
   localparam int STEP_A = 16;
   localparam int UPD_A  = P_A * 4;

   logic clk   = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic rst_c = 1'b1;

   int n_compared   = 0;
   int n_mismatched = 0;

   led_pwm_if if_a ();
   led_pwm_if if_b ();
   led_pwm_if if_c ();

   led_pwm_driver dut_a (
      .clk (clk),
      .rst (rst_a),
      .pwm (if_a)
   );

   led_pwm_driver #(.PWM_BITS(8), .STEP_DIV(4), .STEP(100)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .pwm (if_b)
   );

   led_pwm_driver #(.PWM_BITS(2), .STEP_DIV(1), .STEP(1)) dut_c (
      .clk (clk),
      .rst (rst_c),
      .pwm (if_c)
   );

   // Free-running bench clock
   always #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int expected);
      n_compared++;
      if (actual != expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int step_toward(input int d, input int tgt, input int step);
      if (tgt - d > step) return d + step;
      if (d - tgt > step) return d - step;
      return tgt;
   endfunction

   // Reference model for dut_a. It works from the number of edges since reset:
   //  - counter value    = edge mod 256
   //  - step every 1024 edges, on the last edge of each block
   int         a_edge = 0;
   int         a_duty [3] = '{0, 0, 0};
   logic [2:0] a_rgb = 3'b000;
   bit         chk_a = 1'b0;

   // Model state advance, reset together with dut_a
   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         a_edge <= 0;
         a_duty <= '{0, 0, 0};
         a_rgb  <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            a_rgb[i] <= if_a.enable && (a_duty[i] == MAX_A || (a_edge % P_A) < a_duty[i]);
            if (a_edge % UPD_A == UPD_A - 1) begin
               a_duty[i] <= step_toward(a_duty[i], if_a.colour[i] ? MAX_A : 0, STEP_A);
            end
         end
         a_edge <= a_edge + 1;
      end
   end

   function automatic logic model_busy_a();
      logic b;
      b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (a_duty[i] != (if_a.colour[i] ? MAX_A : 0)) b = 1'b1;
      end
      return b & rst_a;
   endfunction

   // Every-cycle comparison of dut_a pins and busy against the model
   always @(negedge clk) begin
      if (chk_a) begin
         check_output("a_model_rgb_busy", {if_a.rgb, if_a.busy}, {a_rgb, model_busy_a()});
      end
   end

   // Edge counters since reset release for dut_b and dut_c
   int b_edge = 0;
   int c_edge = 0;

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) b_edge <= 0;
      else        b_edge <= b_edge + 1;
   end

   always @(posedge clk or negedge rst_c) begin
      if (!rst_c) c_edge <= 0;
      else        c_edge <= c_edge + 1;
   end

   task automatic wait_done_a(input int k);
      int guard = 0;
      while (a_edge <= k && guard < 40000) begin
         @(negedge clk);
         guard++;
      end
      if (a_edge <= k) check_output("a_wait_timeout", a_edge, k + 1);
   endtask

   task automatic wait_done_b(input int k);
      int guard = 0;
      while (b_edge <= k && guard < 40000) begin
         @(negedge clk);
         guard++;
      end
      if (b_edge <= k) check_output("b_wait_timeout", b_edge, k + 1);
   endtask

   task automatic wait_done_c(input int k);
      int guard = 0;
      while (c_edge <= k && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (c_edge <= k) check_output("c_wait_timeout", c_edge, k + 1);
   endtask

   task automatic apply_stimulus_a(input logic [2:0] col, input logic en);
      @(negedge clk);
      #1;
      if_a.colour = col;
      if_a.enable = en;
   endtask

   task automatic measure_a(output int n2, output int n1, output int n0);
      n2 = 0;
      n1 = 0;
      n0 = 0;
      repeat (P_A) begin
         @(negedge clk);
         n2 += int'(if_a.rgb[2]);
         n1 += int'(if_a.rgb[1]);
         n0 += int'(if_a.rgb[0]);
      end
   endtask

   task automatic test_a();
      int          n2, n1, n0;
      int          len;
      logic [2:0]  col;
      logic        en;

      // Reset: held with colour 111, pins and busy stay low
      if_a.colour = 3'b111;
      if_a.enable = 1'b1;
      #1;
      rst_a = 1'b0;
      chk_a = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check_output("a_reset_rgb", int'(if_a.rgb), 0);
         check_output("a_reset_busy", int'(if_a.busy), 0);
      end
      @(negedge clk);
      #1 rst_a = 1'b1;
      #1 check_output("a_busy_at_release", int'(if_a.busy), 1);
      repeat (8) begin
         @(negedge clk);
         check_output("a_rgb_before_update", int'(if_a.rgb), 0);
      end

      // Fade-up of red from a fresh reset
      @(negedge clk);
      #1 rst_a = 1'b0;
      if_a.colour = 3'b100;
      @(negedge clk);
      #1 rst_a = 1'b1;
      wait_done_a(UPD_A - 1);
      measure_a(n2, n1, n0);
      check_output("a_fade_red_high16", n2, 16);
      check_output("a_fade_green_off", n1, 0);
      check_output("a_fade_blue_off", n0, 0);
      wait_done_a(16 * UPD_A - 2);
      check_output("a_busy_before_land", int'(if_a.busy), 1);
      @(negedge clk);
      check_output("a_busy_after_land", int'(if_a.busy), 0);
      measure_a(n2, n1, n0);
      check_output("a_red_full_high", n2, 256);

      // Redirect at red duty 96 toward green+blue
      @(negedge clk);
      #1 rst_a = 1'b0;
      @(negedge clk);
      #1 rst_a = 1'b1;
      wait_done_a(6 * UPD_A - 1);
      apply_stimulus_a(3'b011, 1'b1);
      wait_done_a(7 * UPD_A - 1);
      measure_a(n2, n1, n0);
      check_output("a_redirect_red80", n2, 80);
      check_output("a_redirect_green16", n1, 16);
      check_output("a_redirect_blue16", n0, 16);
      wait_done_a(22 * UPD_A - 2);
      check_output("a_redirect_busy_held", int'(if_a.busy), 1);
      @(negedge clk);
      check_output("a_redirect_busy_fall", int'(if_a.busy), 0);

      // Enable gating with green at full duty
      apply_stimulus_a(3'b010, 1'b1);
      repeat (20) @(negedge clk);
      apply_stimulus_a(3'b010, 1'b0);
      @(negedge clk);
      check_output("a_gate_rgb_off", int'(if_a.rgb), 0);
      repeat (299) @(negedge clk);
      apply_stimulus_a(3'b010, 1'b1);
      @(negedge clk);
      check_output("a_gate_green_back", int'(if_a.rgb[1]), 1);

      // Random colour/enable segments with occasional mid-cycle resets
      repeat (24) begin
         col = 3'($urandom_range(0, 7));
         en  = ($urandom_range(0, 3) != 0);
         len = $urandom_range(50, 1200);
         apply_stimulus_a(col, en);
         repeat (len) @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            #2 rst_a = 1'b0;
            #1 check_output("a_async_reset_rgb", int'(if_a.rgb), 0);
            @(negedge clk);
            #1 rst_a = 1'b1;
         end
      end
      @(negedge clk);
      chk_a = 1'b0;
   endtask

   typedef struct {
      logic [2:0] colour;
      int         exp_high;
      logic       exp_busy;
   } vec_b_t;

   typedef struct {
      int         last_edge;
      logic [3:0] pattern;
   } vec_c_t;

   task automatic test_b();
      vec_b_t tbl_b [6];
      int     n;

      tbl_b[0] = '{3'b100, 100, 1'b1};
      tbl_b[1] = '{3'b100, 200, 1'b1};
      tbl_b[2] = '{3'b100, 256, 1'b0};
      tbl_b[3] = '{3'b000, 155, 1'b1};
      tbl_b[4] = '{3'b000,  55, 1'b1};
      tbl_b[5] = '{3'b000,   0, 1'b0};

      if_b.colour = 3'b100;
      if_b.enable = 1'b1;
      #1 rst_b = 1'b0;
      @(negedge clk);
      #1 rst_b = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1 if_b.colour = tbl_b[k].colour;
         wait_done_b((k + 1) * UPD_A - 1);
         n = 0;
         repeat (P_A) begin
            @(negedge clk);
            n += int'(if_b.rgb[2]);
         end
         check_output($sformatf("b_step100_high_%0d", k), n, tbl_b[k].exp_high);
         check_output($sformatf("b_step100_busy_%0d", k), int'(if_b.busy), int'(tbl_b[k].exp_busy));
      end
   endtask

   task automatic test_c();
      vec_c_t     tbl_c [3];
      logic [3:0] pat;

      tbl_c[0] = '{3,  4'b1000};
      tbl_c[1] = '{7,  4'b1100};
      tbl_c[2] = '{11, 4'b1111};

      if_c.colour = 3'b100;
      if_c.enable = 1'b1;
      #1 rst_c = 1'b0;
      @(negedge clk);
      #1 rst_c = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_done_c(tbl_c[k].last_edge);
         pat = 4'b0000;
         for (int j = 3; j >= 0; j--) begin
            @(negedge clk);
            pat[j] = if_c.rgb[2];
         end
         check_output($sformatf("c_small_pattern_%0d", k), int'(pat), int'(tbl_c[k].pattern));
      end
      check_output("c_busy_landed", int'(if_c.busy), 0);
      check_output("c_rgb_high_before_reset", int'(if_c.rgb[2]), 1);
      #1 if_c.colour = 3'b000;
      #1 check_output("c_busy_follows_colour", int'(if_c.busy), 1);
      #1 rst_c = 1'b0;
      #1 check_output("c_async_reset_rgb", int'(if_c.rgb), 0);
      check_output("c_async_reset_busy", int'(if_c.busy), 0);
   endtask

   // Overall run limit
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Test sequencing and summary
   initial begin
      fork
         test_a();
         test_b();
         test_c();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
